// File: rtl/seg_pkg.sv
// Segment-code constants shared by the digit decoder and the scan readback path,
// so both ends of the display path use one table.
package seg_pkg;

  localparam int N_DIGITS_DEFAULT = 4;

  // Active-low {g,f,e,d,c,b,a}; bit0 drives segment a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] digit;
  } seg_code_t;

endpackage

// File: rtl/seg_code_lookup.sv
// Combinational inverse of the digit decoder: 7-bit active-low pattern to
// {legal, blank, digit}.
module seg_code_lookup
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output seg_code_t  code_o
);

  always_comb begin
    code_o = '{legal: 1'b0, blank: 1'b0, digit: 4'd0};
    case (pattern_i)
      SEG_0:     code_o = '{legal: 1'b1, blank: 1'b0, digit: 4'd0};
      SEG_1:     code_o = '{legal: 1'b1, blank: 1'b0, digit: 4'd1};
      SEG_2:     code_o = '{legal: 1'b1, blank: 1'b0, digit: 4'd2};
      SEG_3:     code_o = '{legal: 1'b1, blank: 1'b0, digit: 4'd3};
      SEG_4:     code_o = '{legal: 1'b1, blank: 1'b0, digit: 4'd4};
      SEG_5:     code_o = '{legal: 1'b1, blank: 1'b0, digit: 4'd5};
      SEG_BLANK: code_o = '{legal: 1'b1, blank: 1'b1, digit: DIGIT_BLANK};
      default:   code_o = '{legal: 1'b0, blank: 1'b0, digit: 4'd0};
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Recovers digit values from a multiplexed active-low 7-segment bus: waits for
// each scan position to hold steady, decodes it, and publishes whole frames.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int N_DIGITS      = N_DIGITS_DEFAULT,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [6:0]            seg,
  output logic [4*N_DIGITS-1:0] frame_digits,
  output logic [N_DIGITS-1:0]   frame_blank,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int SW = N_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]       CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]       CNT_ONE = CW'(1);
  localparam logic [N_DIGITS-1:0] SEL_ONE = N_DIGITS'(1);

  // Sample word is {an, seg}; all-ones is the idle/dark display.
  logic [SW-1:0] sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d;

  logic [N_DIGITS-1:0] sel_n;
  logic                sel_valid;

  logic [4*N_DIGITS-1:0] work_digits_q, work_digits_d;
  logic [N_DIGITS-1:0]   work_blank_q, work_blank_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic                  publish;

  logic [4*N_DIGITS-1:0] frame_digits_q;
  logic [N_DIGITS-1:0]   frame_blank_q;
  logic                  frame_valid_q;
  logic                  err_q;

  seg_code_t code;

  // prev_q still holds the dwelled pattern in the cycle after the count hits.
  seg_code_lookup u_lookup (
    .pattern_i (prev_q[6:0]),
    .code_o    (code)
  );

  assign sel_n     = ~sync2_q[SW-1:7];
  assign sel_valid = (sel_n != '0) && ((sel_n & (sel_n - SEL_ONE)) == '0);

  always_comb begin
    cnt_d = '0;
    if (sel_valid && (sync2_q == prev_q)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end else if (sel_valid) begin
      cnt_d = CNT_ONE;
    end
  end

  // Fires only on the transition into saturation, so one dwell commits once.
  assign hit_d   = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  assign publish = &seen_q;

  always_comb begin
    work_digits_d = work_digits_q;
    work_blank_d  = work_blank_q;
    seen_d        = seen_q;
    if (publish) begin
      seen_d = '0;
    end
    if (hit_q && code.legal) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (!prev_q[7+i]) begin
          work_digits_d[4*i +: 4] = code.digit;
          work_blank_d[i]         = code.blank;
          seen_d[i]               = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      prev_q         <= '1;
      cnt_q          <= '0;
      hit_q          <= 1'b0;
      work_digits_q  <= '0;
      work_blank_q   <= '0;
      seen_q         <= '0;
      frame_digits_q <= '0;
      frame_blank_q  <= '0;
      frame_valid_q  <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      sync1_q       <= {an, seg};
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      cnt_q         <= cnt_d;
      hit_q         <= hit_d;
      work_digits_q <= work_digits_d;
      work_blank_q  <= work_blank_d;
      seen_q        <= seen_d;
      if (publish) begin
        frame_digits_q <= work_digits_q;
        frame_blank_q  <= work_blank_q;
      end
      frame_valid_q <= publish;
      err_q         <= hit_q && !code.legal;
    end
  end

  assign frame_digits = frame_digits_q;
  assign frame_blank  = frame_blank_q;
  assign frame_valid  = frame_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: a pin-history model predicts every output cycle,
// and directed scans pin the model with hand-computed frames and latency.
module tb_seg_scan_reader;

  localparam int ND = 4;
  localparam int S  = 16;
  localparam int HL = S + 4;

  localparam logic [6:0] C0  = 7'b1000000;
  localparam logic [6:0] C1  = 7'b1111001;
  localparam logic [6:0] C2  = 7'b0100100;
  localparam logic [6:0] C3  = 7'b0110000;
  localparam logic [6:0] C4  = 7'b0011001;
  localparam logic [6:0] C5  = 7'b0010010;
  localparam logic [6:0] CB  = 7'b1111111;
  localparam logic [6:0] BAD = 7'b0000000;
  localparam logic [6:0] BD2 = 7'b0001000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ND-1:0] an  = 4'hF;
  logic [6:0]    seg = 7'h7F;
  logic [4*ND-1:0] frame_digits;
  logic [ND-1:0]   frame_blank;
  logic            frame_valid;
  logic            err;

  always #5 clk = ~clk;

  seg_scan_reader #(.N_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .an           (an),
    .seg          (seg),
    .frame_digits (frame_digits),
    .frame_blank  (frame_blank),
    .frame_valid  (frame_valid),
    .err          (err)
  );

  int tests = 0;
  int fails = 0;
  int fv_seen = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // hist holds the pin samples of the last HL edges; hist[HL-1] is the newest.
  logic [10:0]   hist[$];
  logic [3:0]    m_work[ND];
  logic [ND-1:0] m_wblank, m_seen;
  logic [15:0]   m_frame;
  logic [ND-1:0] m_fblank;
  logic          exp_fv, exp_err;

  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      C0: return {2'b10, 4'd0};
      C1: return {2'b10, 4'd1};
      C2: return {2'b10, 4'd2};
      C3: return {2'b10, 4'd3};
      C4: return {2'b10, 4'd4};
      C5: return {2'b10, 4'd5};
      CB: return {2'b11, 4'hF};
      default: return 6'b0;
    endcase
  endfunction

  function automatic int sel_pos(input logic [3:0] a);
    int n = 0;
    int p = -1;
    for (int i = 0; i < ND; i++) begin
      if (!a[i]) begin
        n++;
        p = i;
      end
    end
    return (n == 1) ? p : -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (HL) hist.push_back(11'h7FF);
    for (int i = 0; i < ND; i++) m_work[i] = 4'd0;
    m_wblank = '0;
    m_seen   = '0;
    m_frame  = '0;
    m_fblank = '0;
    exp_fv   = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_step();
    int p;
    logic stable;
    logic [5:0] c;
    if (rst) begin
      model_reset();
      return;
    end
    hist.push_back({an, seg});
    void'(hist.pop_front());
    exp_fv = (m_seen == 4'hF);
    if (exp_fv) begin
      for (int i = 0; i < ND; i++) m_frame[4*i +: 4] = m_work[i];
      m_fblank = m_wblank;
      m_seen   = '0;
    end
    exp_err = 1'b0;
    // A commit lands when the sample run that ended 3 edges ago reached exactly S.
    p = sel_pos(hist[1][10:7]);
    stable = (p >= 0) && (hist[0] != hist[1]);
    for (int j = 2; j <= S; j++) begin
      if (hist[j] != hist[1]) stable = 1'b0;
    end
    if (stable) begin
      c = decode(hist[1][6:0]);
      if (c[5]) begin
        m_work[p]   = c[3:0];
        m_wblank[p] = c[4];
        m_seen[p]   = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("frame_digits", 32'(frame_digits), 32'(m_frame));
      check("frame_blank", 32'(frame_blank), 32'(m_fblank));
      check("frame_valid", 32'(frame_valid), 32'(exp_fv));
      check("err", 32'(err), 32'(exp_err));
      if (frame_valid === 1'b1) fv_seen++;
      if (err === 1'b1) err_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold_an(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input int pos, input logic [6:0] s, input int n);
    logic [3:0] one;
    one = 4'b0001;
    hold_an((pos < 0) ? 4'hF : ~(one << pos), s, n);
  endtask

  // ---------------- directed sequence ----------------
  int f0, e0, lat;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_digits", 32'(frame_digits), 32'h0);
    check("reset_blank", 32'(frame_blank), 32'h0);
    check("reset_valid", 32'(frame_valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    hold(-1, CB, 4);

    // clean scan 3,1,4,5
    f0 = fv_seen; e0 = err_seen;
    hold(0, C3, 20); hold(1, C1, 20); hold(2, C4, 20); hold(3, C5, 20);
    hold(-1, CB, 5);
    check("clean_fv_count", 32'(fv_seen - f0), 32'd1);
    check("clean_digits", 32'(frame_digits), 32'h5413);
    check("clean_blank", 32'(frame_blank), 32'h0);
    check("clean_err_count", 32'(err_seen - e0), 32'd0);

    // blank and illegal pattern
    f0 = fv_seen; e0 = err_seen;
    hold(0, C0, 20); hold(2, CB, 20); hold(1, BAD, 20); hold(3, C2, 20);
    hold(-1, CB, 5);
    check("blankerr_err_count", 32'(err_seen - e0), 32'd1);
    check("blankerr_no_publish", 32'(fv_seen - f0), 32'd0);
    hold(1, C1, 20);
    hold(-1, CB, 5);
    check("blankerr_fv_count", 32'(fv_seen - f0), 32'd1);
    check("blankerr_digits", 32'(frame_digits), 32'h2F10);
    check("blankerr_blank", 32'(frame_blank), 32'b0100);

    // glitch rejection
    f0 = fv_seen; e0 = err_seen;
    for (int k = 0; k < 8; k++) hold(0, (k % 2 == 0) ? BD2 : C1, 8);
    check("glitch_err_count", 32'(err_seen - e0), 32'd0);
    check("glitch_fv_count", 32'(fv_seen - f0), 32'd0);
    hold(0, C0, 20); hold(1, C3, 20); hold(2, C4, 20); hold(3, C5, 20);
    hold(-1, CB, 5);
    check("glitch_fv_after", 32'(fv_seen - f0), 32'd1);
    check("glitch_digits", 32'(frame_digits), 32'h5430);

    // invalid selection
    f0 = fv_seen; e0 = err_seen;
    hold_an(4'b0011, C1, 100);
    hold_an(4'b1111, C1, 100);
    check("invsel_fv_count", 32'(fv_seen - f0), 32'd0);
    check("invsel_err_count", 32'(err_seen - e0), 32'd0);
    check("invsel_digits", 32'(frame_digits), 32'h5430);

    // latency from last position's pin change, then a long dwell
    f0 = fv_seen; e0 = err_seen;
    hold(0, C1, 20); hold(1, C2, 20); hold(2, C3, 20);
    an  = ~4'b1000;
    seg = C4;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (frame_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency_edges", 32'(lat), 32'(S + 3));
    @(negedge clk);
    repeat (1000) @(negedge clk);
    check("dwell_fv_count", 32'(fv_seen - f0), 32'd1);
    check("dwell_err_count", 32'(err_seen - e0), 32'd0);
    check("dwell_digits", 32'(frame_digits), 32'h4321);

    // reset after three of four positions
    hold(0, C5, 20); hold(1, C4, 20); hold(2, C3, 20);
    rst = 1'b1;
    #1;
    check("midrst_digits", 32'(frame_digits), 32'h0);
    check("midrst_blank", 32'(frame_blank), 32'h0);
    check("midrst_valid", 32'(frame_valid), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    f0 = fv_seen;
    hold(3, C2, 20);
    hold(-1, CB, 5);
    check("midrst_partial_fv", 32'(fv_seen - f0), 32'd0);
    hold(0, C5, 20); hold(1, C4, 20); hold(2, C3, 20); hold(3, C2, 20);
    hold(-1, CB, 5);
    check("midrst_full_fv", 32'(fv_seen - f0), 32'd1);
    check("midrst_full_digits", 32'(frame_digits), 32'h2345);
    check("midrst_full_blank", 32'(frame_blank), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
